// File: rtl/mapu_matrix_loader.sv
// mapu_matrix_loader
//   Collects a stream of DATA_WIDTH-bit words into a pair of DIM x DIM matrices
//   (A then B, row-major) and hands the complete pair to the MAPU with a
//   valid/ready handshake. Framing is checked against i_last: the pair must end
//   with i_last on word 2N-1 and nowhere else, otherwise the pair is dropped and
//   o_err pulses for one cycle.
//
// Ports
//   clk, reset_n   clock, synchronous active-low reset
//   i_vld/o_rdy_in input word handshake (o_rdy_in depends only on state)
//   i_data/i_last  input word and end-of-pair marker
//   o_vld/i_rdy    output pair handshake
//   o_a/o_b        assembled matrices, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_err          one-cycle framing error pulse
module mapu_matrix_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_vld,
  output logic                              o_rdy_in,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic                              i_last,
  output logic                              o_vld,
  input  logic                              i_rdy,
  output logic [DIM*DIM*DATA_WIDTH-1:0]     o_a,
  output logic [DIM*DIM*DATA_WIDTH-1:0]     o_b,
  output logic                              o_err
);

  localparam int N     = DIM * DIM;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    vld_q, rdy_q;
  logic [DATA_WIDTH-1:0]   a_q [N];
  logic [DATA_WIDTH-1:0]   a_d [N];
  logic [DATA_WIDTH-1:0]   b_q [N];
  logic [DATA_WIDTH-1:0]   b_d [N];
  logic                    in_xfer_s;
  logic                    last_slot_s;

  // Input handshake is gated by state only, so the loader never stalls on i_vld.
  assign in_xfer_s   = i_vld && (state_q != PRESENT);
  assign last_slot_s = (cnt_q == CNT_W'(N - 1));

  // Next-state, counter, element-store and error-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD_A: begin
        if (in_xfer_s) begin
          a_d[cnt_q] = i_data;
          if (i_last) begin
            // End marker inside A: drop the partial pair and restart.
            err_d = 1'b1;
            cnt_d = '0;
          end else if (last_slot_s) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD_B: begin
        if (in_xfer_s) begin
          b_d[cnt_q] = i_data;
          if (last_slot_s) begin
            cnt_d = '0;
            if (i_last) begin
              state_d = PRESENT;
            end else begin
              // Final slot reached without the end marker.
              err_d   = 1'b1;
              state_d = LOAD_A;
            end
          end else if (i_last) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      PRESENT: begin
        if (i_rdy) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, storage and registered handshake/error outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= (state_d == PRESENT);
      rdy_q   <= (state_d != PRESENT);
      for (int k = 0; k < N; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  // Flatten the element arrays onto the packed output buses.
  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int k = 0; k < N; k++) begin
      o_a[k*DATA_WIDTH +: DATA_WIDTH] = a_q[k];
      o_b[k*DATA_WIDTH +: DATA_WIDTH] = b_q[k];
    end
  end

  assign o_rdy_in = rdy_q;
  assign o_vld    = vld_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_mapu_matrix_loader.sv
// Testbench for mapu_matrix_loader: directed framing/stall/reset scenarios plus
// randomized traffic, all checked against a word-list reference model.
module tb_mapu_matrix_loader;

  localparam int DW  = 32;
  localparam int DIM = 3;
  localparam int N   = DIM * DIM;
  localparam int W   = N * DW;

  logic          clk;
  logic          reset_n;
  logic          i_vld;
  logic          o_rdy_in;
  logic [DW-1:0] i_data;
  logic          i_last;
  logic          o_vld;
  logic          i_rdy;
  logic [W-1:0]  o_a;
  logic [W-1:0]  o_b;
  logic          o_err;

  int n_tests = 0;
  int n_fail  = 0;

  mapu_matrix_loader #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_vld    (i_vld),
    .o_rdy_in (o_rdy_in),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_vld    (o_vld),
    .i_rdy    (i_rdy),
    .o_a      (o_a),
    .o_b      (o_b),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a list of words received since the last frame boundary;
  // a frame is the 2N words of A followed by B, terminated by i_last.
  logic [DW-1:0] cur_words [$];
  logic [W-1:0]  exp_a_q [$];
  logic [W-1:0]  exp_b_q [$];
  bit            pair_waiting = 1'b0;
  bit            err_pend     = 1'b0;
  int            n_presented  = 0;
  bit            rand_rdy     = 1'b0;

  // Model / monitor evaluated on the falling edge, where all signals are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cur_words.delete();
        exp_a_q.delete();
        exp_b_q.delete();
        pair_waiting = 1'b0;
        err_pend     = 1'b0;
      end else begin
        check_eq("o_err", W'(o_err), W'(err_pend));
        err_pend = 1'b0;
        check_eq("o_vld", W'(o_vld), W'(pair_waiting));
        check_eq("o_rdy_in", W'(o_rdy_in), W'(!pair_waiting));
        if (pair_waiting) begin
          if (exp_a_q.size() > 0) begin
            check_eq("o_a", o_a, exp_a_q[0]);
            check_eq("o_b", o_b, exp_b_q[0]);
          end
          if (i_rdy) begin
            void'(exp_a_q.pop_front());
            void'(exp_b_q.pop_front());
            pair_waiting = 1'b0;
            n_presented++;
          end
        end else if (i_vld) begin
          int idx;
          cur_words.push_back(i_data);
          idx = cur_words.size() - 1;
          if (i_last && idx != 2*N-1) begin
            err_pend = 1'b1;
            cur_words.delete();
          end else if (idx == 2*N-1) begin
            if (i_last) begin
              logic [W-1:0] ea;
              logic [W-1:0] eb;
              for (int k = 0; k < N; k++) begin
                ea[k*DW +: DW] = cur_words[k];
                eb[k*DW +: DW] = cur_words[N+k];
              end
              exp_a_q.push_back(ea);
              exp_b_q.push_back(eb);
              pair_waiting = 1'b1;
            end else begin
              err_pend = 1'b1;
            end
            cur_words.delete();
          end
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) i_rdy = 1'($urandom_range(1));
    end
  end

  // Offer one word, with random idle cycles beforehand, until it is accepted.
  task automatic put_word(input logic [DW-1:0] d, input logic l, input int gap, output int waited);
    bit took;
    waited = 0;
    took   = 1'b0;
    while (gap > 0 && int'($urandom_range(99)) < gap) begin
      i_vld = 1'b0;
      @(posedge clk);
      #1;
    end
    i_vld  = 1'b1;
    i_data = d;
    i_last = l;
    while (!took) begin
      @(negedge clk);
      took = o_rdy_in;
      @(posedge clk);
      #1;
      if (!took) begin
        waited++;
        if (waited > 2000) begin
          check_eq("accept_timeout", W'(1'b1), W'(1'b0));
          took = 1'b1;
        end
      end
    end
    i_vld  = 1'b0;
    i_data = $urandom;
    i_last = 1'($urandom_range(1));
  endtask

  // Send n words; word values base+i (or random), i_last on index last_at.
  task automatic send_seq(input int n, input int last_at, input int gap, input bit rnd, input int base);
    int w;
    for (int i = 0; i < n; i++) begin
      put_word(rnd ? DW'($urandom) : DW'(base + i), (i == last_at), gap, w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_vld"}, W'(o_vld), W'(1'b0));
    check_eq({tag, "_err"}, W'(o_err), W'(1'b0));
    check_eq({tag, "_a"}, o_a, W'(0));
    check_eq({tag, "_b"}, o_b, W'(0));
    check_eq({tag, "_rdy"}, W'(o_rdy_in), W'(1'b1));
  endtask

  initial begin
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           w;
    int           clean_pairs;
    int           guard;

    clean_pairs = 0;
    reset_n = 1'b0;
    i_vld   = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_rdy   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      ea[k*DW +: DW] = DW'(k + 1);
      eb[k*DW +: DW] = DW'(k + 10);
    end

    // Basic pair 1..18, consumer always ready.
    i_rdy = 1'b1;
    send_seq(18, 17, 0, 1'b0, 1);
    clean_pairs++;
    check_eq("t1_vld_rise", W'(o_vld), W'(1'b1));
    check_eq("t1_a", o_a, ea);
    check_eq("t1_b", o_b, eb);
    @(posedge clk);
    #1;
    check_eq("t1_vld_drop", W'(o_vld), W'(1'b0));

    // Consumer stalls for 5 cycles; outputs hold, input side is closed.
    i_rdy = 1'b0;
    send_seq(18, 17, 0, 1'b0, 1);
    clean_pairs++;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_eq("t2_vld_hold", W'(o_vld), W'(1'b1));
      check_eq("t2_rdy_low", W'(o_rdy_in), W'(1'b0));
      check_eq("t2_a_stable", o_a, ea);
      check_eq("t2_b_stable", o_b, eb);
    end
    i_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t2_vld_drop", W'(o_vld), W'(1'b0));
    put_word(DW'(19), 1'b0, 0, w);
    check_eq("t2_w19_wait", W'(w), W'(0));
    send_seq(17, 16, 0, 1'b0, 20);
    clean_pairs++;

    // End marker on word 7.
    send_seq(7, 6, 0, 1'b0, 100);
    check_eq("t3_err_pulse", W'(o_err), W'(1'b1));
    check_eq("t3_no_vld", W'(o_vld), W'(1'b0));
    @(posedge clk);
    #1;
    check_eq("t3_err_drop", W'(o_err), W'(1'b0));
    send_seq(18, 17, 0, 1'b0, 200);
    clean_pairs++;

    // Missing end marker on word 18.
    send_seq(18, -1, 0, 1'b0, 400);
    check_eq("t4_err_pulse", W'(o_err), W'(1'b1));
    check_eq("t4_no_vld", W'(o_vld), W'(1'b0));
    @(posedge clk);
    #1;
    check_eq("t4_err_drop", W'(o_err), W'(1'b0));

    // Reset after 12 words abandons the pair silently.
    send_seq(12, -1, 0, 1'b0, 300);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("t5_reset");
    reset_n = 1'b1;
    send_seq(18, 17, 0, 1'b0, 500);
    clean_pairs++;

    // Long randomized run with 50% input gaps and random back-pressure.
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      send_seq(18, 17, 50, 1'b1, 0);
      clean_pairs++;
    end
    guard = 0;
    while ((pair_waiting || o_vld) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain_timeout", W'(guard < 200), W'(1'b1));
    check_eq("pairs_presented", W'(n_presented), W'(clean_pairs));

    // Random framing: i_last scattered with about 1-in-12 probability.
    for (int i = 0; i < 600; i++) begin
      put_word(DW'($urandom), ($urandom_range(11) == 0), 30, w);
    end
    guard = 0;
    while ((pair_waiting || o_vld) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain2_timeout", W'(guard < 200), W'(1'b1));
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mapu_matrix_loader.md
MAPU_MATRIX_LOADER -- requirements
Module: mapu_matrix_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one matrix element and of the input word.
REQ-002 Parameter DIM, default 3: matrix dimension; one matrix is N = DIM*DIM elements.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 i_vld  input  1  input word valid.
REQ-007 o_rdy_in  output  1  loader accepts an input word this cycle.
REQ-008 i_data  input  DATA_WIDTH  matrix element, row-major, matrix A then matrix B.
REQ-009 i_last  input  1  marks the final word of an A+B pair (word index 2N-1).
REQ-010 o_vld  output  1  an assembled A/B pair is presented to the MAPU.
REQ-011 i_rdy  input  1  MAPU accepts the presented pair.
REQ-012 o_a  output  N*DATA_WIDTH  matrix A; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 o_b  output  N*DATA_WIDTH  matrix B; same packing.
REQ-014 o_err  output  1  one-cycle pulse on a framing error.

Function
REQ-015 An input transfer occurs on a cycle with i_vld=1 and o_rdy_in=1; an output transfer occurs on a cycle with o_vld=1 and i_rdy=1.
REQ-016 FSM states: LOAD_A, LOAD_B, PRESENT; state after reset is LOAD_A.
REQ-017 Word counter cnt, width clog2(N), cleared on reset and on every state change.
REQ-018 In LOAD_A, each input transfer writes A[cnt] and increments cnt; the transfer with cnt=N-1 moves the FSM to LOAD_B.
REQ-019 In LOAD_B, each input transfer writes B[cnt] and increments cnt; the transfer with cnt=N-1 and i_last=1 moves the FSM to PRESENT.
REQ-020 o_rdy_in is 1 in LOAD_A and LOAD_B and 0 in PRESENT; it is purely a function of state, never of i_vld.
REQ-021 o_vld is 1 exactly in PRESENT; o_a and o_b are stable while o_vld=1 and i_rdy=0.
REQ-022 An output transfer in PRESENT moves the FSM to LOAD_A on the next edge, and o_vld drops that edge.
REQ-023 Latency: the first input word of the next pair is accepted the cycle after the output transfer; there is no bypass.
REQ-024 Early-last error: i_last=1 on any input transfer other than LOAD_B with cnt=N-1 pulses o_err next cycle, discards the partial pair, and returns the FSM to LOAD_A with cnt=0.
REQ-025 Missing-last error: the LOAD_B transfer at cnt=N-1 with i_last=0 pulses o_err next cycle, discards the pair, and returns the FSM to LOAD_A.
REQ-026 A discarded pair is never presented; o_a and o_b contents after an error are don't-care until the next PRESENT.
REQ-027 Only the counter is cleared on an error; stored elements are overwritten by subsequent loads.
REQ-028 o_err is registered and is high for exactly one cycle per error.
REQ-029 i_data and i_last are ignored when no input transfer occurs; i_rdy is ignored outside PRESENT.

Reset
REQ-030 When reset_n=0 at a rising edge: FSM=LOAD_A, cnt=0, o_vld=0, o_err=0, o_a=0, o_b=0; o_rdy_in=1 from the first cycle after reset.
REQ-031 Reset mid-load or in PRESENT abandons the pair with no o_err pulse and no output transfer.

Verification
REQ-032 Stream 18 words 1..18, i_last on word 18, i_rdy=1 -> o_vld rises the cycle after word 18; o_a elements = 1..9, o_b elements = 10..18, k=0 in the LSBs; o_vld drops after 1 cycle.
REQ-033 Same stream with i_rdy=0 for 5 cycles -> o_vld held 5+ cycles, o_a/o_b stable, o_rdy_in=0 throughout; word 19 is accepted the cycle after the transfer.
REQ-034 i_last on word 7 -> o_err pulses 1 cycle, no o_vld; the next clean 18-word pair is presented correctly.
REQ-035 18 words with no i_last -> o_err on the cycle after word 18, no o_vld.
REQ-036 reset_n=0 after 12 words -> all outputs are at reset values, o_err=0; a fresh 18-word pair is presented correctly.
REQ-037 Random i_vld/i_rdy gaps (50%) over 1000 pairs -> every pair is presented exactly once, in order, with matching data.
